// File: rtl/priority_scan_encoder.sv
// rtl/priority_scan_encoder.sv - streams the index of every set request bit, one beat per output transfer
// A vector is latched into a residual mask and one bit is retired per accepted beat.
module priority_scan_encoder #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_vec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             out_zero_o,
  output logic             out_onehot_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             onehot_q, onehot_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_bit;
  logic             at_most_one;
  logic             vec_onehot;
  logic             scan;
  logic             in_fire;
  logic             out_fire;

  // The last match written wins, so the loop direction picks the priority end.
  always_comb begin
    sel_idx = '0;
    sel_bit = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (residual_q[i]) begin
          sel_idx    = IDX_W'(i);
          sel_bit    = '0;
          sel_bit[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (residual_q[i]) begin
          sel_idx    = IDX_W'(i);
          sel_bit    = '0;
          sel_bit[i] = 1'b1;
        end
      end
    end
  end

  assign at_most_one = (residual_q & (residual_q - WIDTH'(1))) == '0;
  assign vec_onehot  = (in_vec_i != '0) && ((in_vec_i & (in_vec_i - WIDTH'(1))) == '0);

  assign scan         = (state_q == SCAN);
  assign out_valid_o  = scan;
  assign out_idx_o    = scan ? sel_idx : '0;
  assign out_last_o   = scan & at_most_one;
  assign out_zero_o   = scan & (residual_q == '0);
  assign out_onehot_o = scan & onehot_q;

  // A new vector may only land on the cycle the final beat of the current one leaves.
  assign in_ready_o = ~scan | (out_last_o & out_ready_i);
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_o & out_ready_i;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    onehot_d   = onehot_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          residual_d = in_vec_i;
          onehot_d   = vec_onehot;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (out_fire) begin
          residual_d = residual_q & ~sel_bit;
          if (out_last_o) begin
            state_d = IDLE;
          end
        end
        if (in_fire) begin
          residual_d = in_vec_i;
          onehot_d   = vec_onehot;
          state_d    = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      residual_q <= '0;
      onehot_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      onehot_q   <= onehot_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb/tb_priority_scan_encoder.sv - randomized and directed checks of both scan orders against a beat-list model
module tb_priority_scan_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_vec = '0;
  logic        out_ready = 1'b1;

  logic       in_ready_l, out_valid_l, out_last_l, out_zero_l, out_onehot_l;
  logic [3:0] out_idx_l;
  logic       in_ready_m, out_valid_m, out_last_m, out_zero_m, out_onehot_m;
  logic [3:0] out_idx_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    int idx;
    bit last;
    bit zero;
    bit onehot;
  } beat_t;
  typedef beat_t beat_q_t[$];

  beat_q_t q_l, q_m;
  int log_l[$], log_m[$], log_cyc[$], log_last[$];

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(16), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_l),
    .in_vec_i(in_vec), .out_valid_o(out_valid_l), .out_ready_i(out_ready),
    .out_idx_o(out_idx_l), .out_last_o(out_last_l), .out_zero_o(out_zero_l),
    .out_onehot_o(out_onehot_l)
  );

  priority_scan_encoder #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
    .in_vec_i(in_vec), .out_valid_o(out_valid_m), .out_ready_i(out_ready),
    .out_idx_o(out_idx_m), .out_last_o(out_last_m), .out_zero_o(out_zero_m),
    .out_onehot_o(out_onehot_m)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beat list for a vector: set-bit indices in scan order, or one zero beat.
  function automatic beat_q_t build(input logic [15:0] v, input bit lsb);
    beat_q_t r;
    int pc;
    pc = $countones(v);
    if (v == 16'h0) begin
      r.push_back('{idx: 0, last: 1'b1, zero: 1'b1, onehot: 1'b0});
    end else begin
      for (int k = 0; k < 16; k++) begin
        int i;
        i = lsb ? k : 15 - k;
        if (v[i]) r.push_back('{idx: i, last: 1'b0, zero: 1'b0, onehot: (pc == 1)});
      end
      r[r.size() - 1].last = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_rdy, ofire, ifire;
    exp_rdy = (q_l.size() == 0) || (q_l.size() == 1 && out_ready);
    if (!rst) begin
      chk("in_ready_lsb", in_ready_l, exp_rdy);
      chk("in_ready_msb", in_ready_m, exp_rdy);
      chk("out_valid_lsb", out_valid_l, q_l.size() != 0);
      chk("out_valid_msb", out_valid_m, q_m.size() != 0);
      if (q_l.size() != 0) begin
        chk("idx_lsb", out_idx_l, q_l[0].idx);
        chk("last_lsb", out_last_l, q_l[0].last);
        chk("zero_lsb", out_zero_l, q_l[0].zero);
        chk("onehot_lsb", out_onehot_l, q_l[0].onehot);
      end
      if (q_m.size() != 0) begin
        chk("idx_msb", out_idx_m, q_m[0].idx);
        chk("last_msb", out_last_m, q_m[0].last);
        chk("zero_msb", out_zero_m, q_m[0].zero);
        chk("onehot_msb", out_onehot_m, q_m[0].onehot);
      end
    end
    if (rst) begin
      q_l.delete();
      q_m.delete();
    end else begin
      ofire = (q_l.size() != 0) && out_ready;
      ifire = in_valid && exp_rdy;
      if (ofire) begin
        log_l.push_back(out_idx_l);
        log_m.push_back(out_idx_m);
        log_last.push_back(out_last_l);
        log_cyc.push_back(cyc);
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (ifire) begin
        q_l = {q_l, build(in_vec, 1'b1)};
        q_m = {q_m, build(in_vec, 1'b0)};
      end
    end
    cyc++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_logs();
    log_l.delete();
    log_m.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  // Holds the vector until accepted; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [15:0] v);
    bit acc;
    in_valid = 1'b1;
    in_vec   = v;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      acc = in_ready_l;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout vector=%h not accepted within 300 cycles", v);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (q_l.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout %0d beats still pending", q_l.size());
  endtask

  initial begin
    int e2l[4] = '{0, 5, 10, 15};
    int e2m[4] = '{15, 10, 5, 0};
    int e5[3]  = '{0, 4, 14};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid_l, 0);
    chk("rst_in_ready", in_ready_l, 1);
    chk("rst_out_idx", out_idx_l, 0);
    chk("rst_out_last", out_last_l, 0);
    chk("rst_out_zero", out_zero_l, 0);
    chk("rst_out_onehot", out_onehot_l, 0);
    @(posedge clk);
    #1;

    // single one-hot vector, latency 1
    clear_logs();
    send(16'h0002);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_after_accept", out_valid_l, 1);
    chk("t1_idx", out_idx_l, 1);
    chk("t1_onehot", out_onehot_l, 1);
    chk("t1_last", out_last_l, 1);
    drain();
    chk("t1_beats", log_l.size(), 1);

    // multi-bit vector in both orders
    clear_logs();
    send(16'h8421);
    drain();
    chk("t2_beats", log_l.size(), 4);
    for (int i = 0; i < 4 && i < log_l.size(); i++) begin
      chk("t2_idx_lsb", log_l[i], e2l[i]);
      chk("t2_idx_msb", log_m[i], e2m[i]);
      chk("t2_last", log_last[i], (i == 3));
      if (i > 0) chk("t2_consecutive", log_cyc[i] - log_cyc[i-1], 1);
    end

    // zero vector
    clear_logs();
    send(16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_zero", out_zero_l, 1);
    chk("t3_last", out_last_l, 1);
    chk("t3_idx", out_idx_l, 0);
    drain();
    chk("t3_beats", log_l.size(), 1);

    // stall with out_ready low
    clear_logs();
    out_ready = 1'b0;
    send(16'h0300);
    in_valid = 1'b1;
    in_vec   = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_idx", out_idx_l, 8);
      chk("t4_hold_ready", in_ready_l, 0);
      chk("t4_hold_valid", out_valid_l, 1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t4_beats", log_l.size(), 2);
    if (log_l.size() == 2) begin
      chk("t4_idx0", log_l[0], 8);
      chk("t4_idx1", log_l[1], 9);
    end

    // back-to-back one-hot vectors
    clear_logs();
    send(16'h0001);
    send(16'h0010);
    send(16'h4000);
    drain();
    chk("t5_beats", log_l.size(), 3);
    for (int i = 0; i < 3 && i < log_l.size(); i++) begin
      chk("t5_idx", log_l[i], e5[i]);
      if (i > 0) chk("t5_no_bubble", log_cyc[i] - log_cyc[i-1], 1);
    end

    // reset in the middle of a scan
    clear_logs();
    send(16'hFFFF);
    in_valid = 1'b0;
    for (int n = 0; n < 50 && log_l.size() < 3; n++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", out_valid_l, 0);
    chk("t6_ready_after_rst", in_ready_l, 1);
    @(posedge clk);
    #1;
    chk("t6_beats_before_rst", log_l.size(), 3);
    clear_logs();
    send(16'h0004);
    drain();
    chk("t6_next_beats", log_l.size(), 1);
    if (log_l.size() == 1) chk("t6_next_idx", log_l[0], 2);

    // randomized traffic with random backpressure and occasional reset
    rnd_rdy = 1'b1;
    for (int t = 0; t < 400; t++) begin
      logic [15:0] v;
      case ($urandom_range(0, 3))
        0: v = 16'h0;
        1: v = 16'h1 << $urandom_range(0, 15);
        2: v = 16'($urandom & $urandom);
        default: v = 16'($urandom);
      endcase
      send(v);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
        end
      end
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
